// File: rtl/vga_ctl_pkg.sv
// vga_ctl_pkg: pixel DMA control-slave register map and swap sequencer state type.
// Revision 1.0
`default_nettype none

package vga_ctl_pkg;

  localparam logic [1:0] REG_FRONT  = 2'd0;
  localparam logic [1:0] REG_BACK   = 2'd1;
  localparam logic [1:0] REG_RES    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int STATUS_PENDING_BIT = 0;

  typedef enum logic [3:0] {
    INIT_BACK = 4'd0,
    TRIG      = 4'd1,
    POLL_RD   = 4'd2,
    POLL_CHK  = 4'd3,
    GAP       = 4'd4,
    FIX_BACK  = 4'd5,
    DONE      = 4'd6,
    ACK_ERR   = 4'd7,
    IDLE      = 4'd8
  } swap_state_t;

endpackage

`default_nettype wire

// File: rtl/pixel_swap_ctrl.sv
// pixel_swap_ctrl: double-buffer init and front/back swap sequencer for the pixel DMA.
// Revision 1.0
`default_nettype none

module pixel_swap_ctrl
  import vga_ctl_pkg::*;
#(
  parameter logic [31:0] BUF0_ADDR = 32'h0800_0000,
  parameter logic [31:0] BUF1_ADDR = 32'h0804_0000,
  parameter int          POLL_GAP  = 4,
  parameter int          TIMEOUT   = 2_000_000
) (
  input  logic        sys_clk_clk,
  input  logic        sys_reset_reset_n,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        busy,
  output logic        timeout_err,
  output logic [31:0] draw_base,
  output logic [1:0]  ctl_address,
  output logic [3:0]  ctl_byteenable,
  output logic        ctl_read,
  output logic        ctl_write,
  output logic [31:0] ctl_writedata,
  input  logic [31:0] ctl_readdata
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [TW-1:0] TLIM  = TW'(TIMEOUT);
  localparam logic [GW-1:0] GLAST = GW'(POLL_GAP - 1);

  swap_state_t   state;
  swap_state_t   next_state;
  logic          init;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;

  logic          acc_rd;
  logic          acc_wr;
  logic [1:0]    acc_addr;
  logic [31:0]   acc_data;

  logic          unused_rd;
  assign unused_rd = ^ctl_readdata[31:1];

  // INIT_BACK holds for one extra cycle so its own write is issued before TRIG.
  always_comb begin
    next_state = state;
    case (state)
      INIT_BACK: if (ctl_write) next_state = TRIG;
      TRIG:      next_state = POLL_RD;
      POLL_RD:   next_state = POLL_CHK;
      POLL_CHK: begin
        if (!ctl_readdata[STATUS_PENDING_BIT]) next_state = init ? FIX_BACK : DONE;
        else if (tcnt >= TLIM)                 next_state = ACK_ERR;
        else                                   next_state = GAP;
      end
      GAP:       if (gcnt == GLAST) next_state = POLL_RD;
      FIX_BACK:  next_state = IDLE;
      DONE:      next_state = IDLE;
      ACK_ERR:   next_state = IDLE;
      IDLE:      if (swap_req) next_state = TRIG;
      default:   next_state = INIT_BACK;
    endcase
  end

  // Bus access belonging to the state being entered, so ctl_* can be registered.
  always_comb begin
    acc_rd   = 1'b0;
    acc_wr   = 1'b0;
    acc_addr = 2'd0;
    acc_data = 32'd0;
    case (next_state)
      INIT_BACK: begin acc_wr = 1'b1; acc_addr = REG_BACK;  acc_data = BUF0_ADDR; end
      TRIG:      begin acc_wr = 1'b1; acc_addr = REG_FRONT; end
      POLL_RD:   begin acc_rd = 1'b1; acc_addr = REG_STATUS; end
      FIX_BACK:  begin acc_wr = 1'b1; acc_addr = REG_BACK;  acc_data = BUF1_ADDR; end
      default:   ;
    endcase
  end

  always_ff @(posedge sys_clk_clk) begin
    if (!sys_reset_reset_n) state <= INIT_BACK;
    else                    state <= next_state;
  end

  always_ff @(posedge sys_clk_clk) begin
    if (!sys_reset_reset_n) begin
      init           <= 1'b1;
      busy           <= 1'b1;
      swap_ack       <= 1'b0;
      timeout_err    <= 1'b0;
      draw_base      <= BUF1_ADDR;
      ctl_address    <= 2'd0;
      ctl_byteenable <= 4'h0;
      ctl_read       <= 1'b0;
      ctl_write      <= 1'b0;
      ctl_writedata  <= 32'd0;
      tcnt           <= '0;
      gcnt           <= '0;
    end else begin
      busy           <= (next_state != IDLE);
      swap_ack       <= (next_state == DONE) || (next_state == ACK_ERR);
      ctl_address    <= acc_addr;
      ctl_byteenable <= (acc_rd || acc_wr) ? 4'hF : 4'h0;
      ctl_read       <= acc_rd;
      ctl_write      <= acc_wr;
      ctl_writedata  <= acc_data;

      if (state == TRIG)
        tcnt <= '0;
      else if ((state == POLL_RD || state == POLL_CHK || state == GAP) && tcnt != '1)
        tcnt <= tcnt + TW'(1);

      if (state == GAP) gcnt <= gcnt + GW'(1);
      else              gcnt <= '0;

      if (state == INIT_BACK) init <= 1'b1;
      if (next_state == FIX_BACK) begin
        init      <= 1'b0;
        draw_base <= BUF1_ADDR;
      end
      if (next_state == DONE)
        draw_base <= (draw_base == BUF1_ADDR) ? BUF0_ADDR : BUF1_ADDR;
      if (next_state == ACK_ERR) timeout_err <= 1'b1;
      if (state == IDLE && swap_req) timeout_err <= 1'b0;
    end
  end

endmodule

`default_nettype wire
